// File: rtl/scramble_key_gen.sv
// Per-frame 24-bit permutation key generator: a Fisher-Yates shuffle of bins 0..7 driven by a
// seeded 16-bit Galois LFSR, one swap per cycle, published as eight packed 3-bit indices.
module scramble_key_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_seed_load,
    input  logic [15:0] i_seed,
    input  logic        i_frame_start,
    input  logic        i_bypass,
    output logic [23:0] o_current_key,
    output logic        o_key_valid,
    output logic        o_busy,
    output logic        o_overrun
);

    typedef enum logic [1:0] {
        StIdle,
        StShuffle,
        StPublish
    } state_e;

    state_e      r_state;
    logic [15:0] r_lfsr;
    logic [2:0]  r_idx;
    logic [2:0]  r_perm [8];
    logic [23:0] r_current_key;
    logic        r_key_valid;
    logic        r_busy;
    logic        r_overrun;

    logic [15:0] w_lfsr_next;
    logic [15:0] w_seed_eff;
    logic [3:0]  w_count;
    logic [2:0]  w_j;
    logic [2:0]  w_perm_swapped [8];
    logic [23:0] w_key;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_seed_eff  = (i_seed == 16'h0000) ? SEED : i_seed;

    // j = floor(lfsr[7:0] * (i+1) / 256) is always <= i, so no modulo bias correction is needed.
    assign w_count = {1'b0, r_idx} + 4'd1;
    assign w_j     = 3'(({4'b0000, r_lfsr[7:0]} * {8'h00, w_count}) >> 8);

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (3'(k) == r_idx) begin
                w_perm_swapped[k] = r_perm[w_j];
            end else if (3'(k) == w_j) begin
                w_perm_swapped[k] = r_perm[r_idx];
            end else begin
                w_perm_swapped[k] = r_perm[k];
            end
        end
    end

    always_comb begin
        w_key = 24'h000000;
        for (int k = 0; k < 8; k++) begin
            w_key = {w_key[20:0], r_perm[k]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_lfsr        <= SEED;
            r_idx         <= 3'd7;
            r_current_key <= 24'h000000;
            r_key_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_perm[k] <= 3'(k);
            end
        end else if (i_enable) begin
            r_key_valid <= 1'b0;
            r_overrun   <= i_frame_start && (r_state != StIdle);
            unique case (r_state)
                StIdle: begin
                    // Seed load and frame start together: the shuffle sees the new seed.
                    if (i_seed_load) begin
                        r_lfsr <= w_seed_eff;
                    end
                    if (i_frame_start) begin
                        r_state <= StShuffle;
                        r_busy  <= 1'b1;
                        r_idx   <= 3'd7;
                        for (int k = 0; k < 8; k++) begin
                            r_perm[k] <= 3'(k);
                        end
                    end
                end
                StShuffle: begin
                    r_perm <= w_perm_swapped;
                    r_lfsr <= w_lfsr_next;
                    r_idx  <= r_idx - 3'd1;
                    if (r_idx == 3'd1) begin
                        r_state <= StPublish;
                    end
                end
                StPublish: begin
                    r_current_key <= i_bypass ? 24'h000000 : w_key;
                    r_key_valid   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end else begin
            // Frozen: levels hold, single-cycle pulses are not stretched.
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign o_current_key = r_current_key;
    assign o_key_valid   = r_key_valid;
    assign o_busy        = r_busy;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_scramble_key_gen.sv
// Bench for scramble_key_gen: directed sequence plus randomised frames, checked against an
// array-based Fisher-Yates reference model that tracks the LFSR as plain integer arithmetic.
module tb_scramble_key_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_enable;
    logic        i_seed_load;
    logic [15:0] i_seed;
    logic        i_frame_start;
    logic        i_bypass;
    logic [23:0] o_current_key;
    logic        o_key_valid;
    logic        o_busy;
    logic        o_overrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr;

    always #5 clock = ~clock;

    scramble_key_gen dut (
        .clock        (clock),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_seed_load  (i_seed_load),
        .i_seed       (i_seed),
        .i_frame_start(i_frame_start),
        .i_bypass     (i_bypass),
        .o_current_key(o_current_key),
        .o_key_valid  (o_key_valid),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One frame of the reference: shuffle from the current model LFSR, then advance it.
    task automatic model_frame(output logic [23:0] key);
        int          p[8];
        int          j;
        int          t;
        logic [15:0] l;
        l = m_lfsr;
        for (int k = 0; k < 8; k++) p[k] = k;
        for (int i = 7; i >= 1; i--) begin
            j    = (int'(l[7:0]) * (i + 1)) / 256;
            t    = p[i];
            p[i] = p[j];
            p[j] = t;
            l    = lfsr_step(l);
        end
        key = 24'h000000;
        for (int k = 0; k < 8; k++) key = {key[20:0], 3'(p[k])};
        m_lfsr = l;
    endtask

    task automatic check_perm(input string tag, input logic [23:0] key);
        logic [7:0]  seen;
        logic [23:0] kv;
        seen = 8'h00;
        kv   = key;
        for (int k = 0; k < 8; k++) seen[kv[3*k +: 3]] = 1'b1;
        check(tag, {16'h0000, seen}, 24'h0000FF);
    endtask

    // Issues frame_start (optionally with a seed load) and waits for the key, checking it.
    task automatic do_frame(input bit byp, input bit gaps, input bit ld, input logic [15:0] sd,
                            input string tag);
        logic [23:0] k;
        int          cyc;
        bit          seen;
        i_enable      = 1'b1;
        i_bypass      = byp;
        i_frame_start = 1'b1;
        i_seed_load   = ld;
        i_seed        = sd;
        if (ld) m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
        tick();
        i_frame_start = 1'b0;
        i_seed_load   = 1'b0;
        check({tag, "_busy_start"}, {23'b0, o_busy}, 24'd1);
        check({tag, "_valid_clear"}, {23'b0, o_key_valid}, 24'd0);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 200) begin
            i_enable = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            cyc++;
            if (o_key_valid) seen = 1'b1;
        end
        i_enable = 1'b1;
        check({tag, "_valid_seen"}, {23'b0, seen}, 24'd1);
        if (!gaps) check({tag, "_latency"}, 24'(cyc), 24'd8);
        model_frame(k);
        check({tag, "_key"}, o_current_key, byp ? 24'h000000 : k);
        check({tag, "_busy_end"}, {23'b0, o_busy}, 24'd0);
        if (!byp) check_perm({tag, "_perm"}, o_current_key);
    endtask

    initial begin
        logic [23:0] k;
        int          kv_count;

        reset         = 1'b1;
        i_enable      = 1'b1;
        i_seed_load   = 1'b0;
        i_seed        = 16'h0000;
        i_frame_start = 1'b0;
        i_bypass      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("reset_key", o_current_key, 24'h000000);
            check("reset_valid", {23'b0, o_key_valid}, 24'd0);
            check("reset_busy", {23'b0, o_busy}, 24'd0);
        end
        m_lfsr = 16'hACE1;
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "reset_frame");

        // Known vector from seed 1, then its successor frame.
        i_seed_load = 1'b1;
        i_seed      = 16'h0001;
        tick();
        i_seed_load = 1'b0;
        m_lfsr      = 16'h0001;
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "known");
        check("known_const", o_current_key, 24'h662BB8);
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "after_known");

        // Zero seed maps to the default seed.
        i_seed_load = 1'b1;
        i_seed      = 16'h0000;
        tick();
        i_seed_load = 1'b0;
        m_lfsr      = 16'hACE1;
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "zero_seed");

        // Seed load in the same cycle as frame_start.
        do_frame(1'b0, 1'b0, 1'b1, 16'h0001, "same_cycle_seed");
        check("same_cycle_const", o_current_key, 24'h662BB8);

        do_frame(1'b1, 1'b0, 1'b0, 16'h0000, "bypass");
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "post_bypass");

        // Requests while disabled are ignored.
        i_enable      = 1'b0;
        i_frame_start = 1'b1;
        i_seed_load   = 1'b1;
        i_seed        = 16'h0005;
        tick();
        i_frame_start = 1'b0;
        i_seed_load   = 1'b0;
        i_enable      = 1'b1;
        check("disabled_busy", {23'b0, o_busy}, 24'd0);
        tick();
        check("disabled_busy_after", {23'b0, o_busy}, 24'd0);
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "after_disabled");

        // Overrun at T+4, seed_load while busy ignored, exactly one key_valid at T+8.
        i_frame_start = 1'b1;
        tick();
        kv_count = 0;
        model_frame(k);
        for (int c = 1; c <= 12; c++) begin
            i_frame_start = (c == 4);
            i_seed_load   = (c == 2);
            i_seed        = 16'h1234;
            tick();
            if (o_key_valid) kv_count++;
            if (c == 4) check("overrun_pulse", {23'b0, o_overrun}, 24'd1);
            if (c == 5) check("overrun_clear", {23'b0, o_overrun}, 24'd0);
            if (c == 8) begin
                check("overrun_valid_t8", {23'b0, o_key_valid}, 24'd1);
                check("overrun_key", o_current_key, k);
            end
        end
        i_frame_start = 1'b0;
        i_seed_load   = 1'b0;
        check("overrun_valid_count", 24'(kv_count), 24'd1);
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "after_overrun");

        // An 8-cycle frame period overruns on the publish cycle.
        i_frame_start = 1'b1;
        tick();
        model_frame(k);
        for (int c = 1; c <= 8; c++) begin
            i_frame_start = (c == 8);
            tick();
        end
        i_frame_start = 1'b0;
        check("period8_overrun", {23'b0, o_overrun}, 24'd1);
        check("period8_valid", {23'b0, o_key_valid}, 24'd1);
        check("period8_key", o_current_key, k);
        tick();
        check("period8_idle", {23'b0, o_busy}, 24'd0);

        // Reset mid-shuffle aborts without publishing.
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", {23'b0, o_busy}, 24'd0);
        check("midreset_key", o_current_key, 24'h000000);
        kv_count = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (o_key_valid) kv_count++;
        end
        check("midreset_no_publish", 24'(kv_count), 24'd0);
        m_lfsr = 16'hACE1;
        do_frame(1'b0, 1'b0, 1'b0, 16'h0000, "after_midreset");

        for (int f = 0; f < 1000; f++) begin
            do_frame($urandom_range(0, 7) == 0, 1'b1, 1'b0, 16'h0000, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scramble_key_gen.md
# scramble_key_gen

Generates the per-frame 24-bit permutation key consumed by the 8-bin frequency-domain scrambler. The key is eight 3-bit bin indices, a true permutation of 0..7. The block sits between the FFT framing counter and the scrambler: on each frame start it runs a Fisher-Yates shuffle driven by a seeded 16-bit LFSR, then publishes the key. A matching instance with the same seed at the receiver reproduces the identical key sequence for descrambling.

## Interface
- SEED, 16'hACE1, LFSR value used at reset and whenever a zero seed is loaded
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  low freezes all state (FSM, LFSR, perm, outputs); frame_start and seed_load are ignored while low
- seed_load  input  1  loads seed into the LFSR; acted on only in IDLE
- seed  input  16  new LFSR value; 16'h0 is replaced by SEED
- frame_start  input  1  single-cycle pulse marking the start of an 8-sample frame
- bypass  input  1  when high at publish, the published key is 24'h0 (scrambler pass-through)
- current_key  output  24  published key, perm[0] in [23:21] … perm[7] in [2:0]; registered
- key_valid  output  1  one-cycle pulse on the cycle current_key changes
- busy  output  1  high while in SHUFFLE or PUBLISH
- overrun  output  1  one-cycle pulse when frame_start arrives while busy

## Operation
- LFSR: 16-bit Galois, right shift. next = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0). It advances exactly once per SHUFFLE cycle and holds otherwise.
- perm[0..7] is a 3-bit array. It is reset to identity at entry to every shuffle, so each key depends only on LFSR state.
- FSM IDLE:
  - seed_load loads the LFSR.
  - frame_start moves to SHUFFLE with i=7 and perm=identity.
  - If both are high in the same cycle, the seed loads first and the shuffle uses the new seed.
- FSM SHUFFLE: one step per cycle.
  - prod[11:0] = lfsr[7:0] * (i+1); j = prod[10:8], which always satisfies j ≤ i.
  - Swap perm[i] and perm[j]; j == i means no change.
  - Advance the LFSR and decrement i. After the i=1 step, go to PUBLISH.
- FSM PUBLISH:
  - current_key <= bypass ? 24'h0 : {perm[0],…,perm[7]}.
  - key_valid pulses; return to IDLE.
- With bypass high, the LFSR still advances, so transmit and receive stay in sync.
- A frame_start received while busy is dropped and overrun pulses; the shuffle in progress is unaffected. seed_load while busy is ignored.
- A published non-bypass key is never 24'h0, because a permutation is never all zeros.

## Timing
- Reset values:
  - current_key = 24'h0, key_valid = 0, busy = 0, overrun = 0.
  - LFSR = SEED, perm = identity, FSM = IDLE, i = 7.
- Reset mid-shuffle aborts immediately; nothing is published.
- Latency:
  - frame_start sampled at edge T.
  - SHUFFLE steps occur on edges T+1 to T+7.
  - current_key updates and key_valid goes high on edge T+8.
  - The FSM returns to IDLE on edge T+8; busy is high from T to T+8 exclusive of IDLE.
- Back-to-back: the next frame_start is accepted from the cycle after key_valid. The minimum frame period is 9 cycles, so an 8-cycle frame period overruns.
- enable low mid-shuffle stalls in place and resumes with identical results. A key_valid pulse is not stretched (outputs hold, pulses clear).
- Identity key for reference: 24'h053977.

## Test plan
- Reset check: reset for 2 cycles, then idle 20 cycles -> current_key=24'h0, key_valid=0, busy=0 throughout.
- Known vector: seed_load with seed=16'h0001, then frame_start -> 8 cycles later current_key=24'h662BB8 with a one-cycle key_valid, and the LFSR reads 16'h02D0.
- Zero seed: seed_load with seed=0, then frame_start -> key equals that produced after reset with SEED=16'hACE1.
- Bypass: bypass=1 for one frame -> current_key=24'h0 with key_valid. The next frame with bypass=0 yields the same key a non-bypassed reference model produces for its second frame.
- Overrun: frame_start at T and T+4 -> overrun pulse at T+4, exactly one key_valid at T+8.
- Randomised: 1000 frames at 9-cycle period with random enable gaps -> every key is a valid permutation and matches the reference model bit-exactly.
